// File: rtl/spi_xfer_sequencer_if.sv
// Bundle between the requesters, the sequencer and the SPI master interface.
// The sequencer uses the slave modport. The requester/SPI side uses the master modport.
`timescale 1ns/1ps
interface spi_xfer_sequencer_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_cfg;
  logic [8*NREQ-1:0] req_tx;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [7:0]        rx_data;
  logic              busy;
  logic              spi_enable;
  logic              spi_cpol;
  logic              spi_cpha;
  logic [1:0]        spi_clk_sel;
  logic [7:0]        spi_master_data_in;
  logic [7:0]        spi_master_data_out;

  modport slave (
    input  req, req_cfg, req_tx, spi_master_data_out,
    output grant, done, rx_data, busy,
           spi_enable, spi_cpol, spi_cpha, spi_clk_sel, spi_master_data_in
  );

  modport master (
    output req, req_cfg, req_tx, spi_master_data_out,
    input  grant, done, rx_data, busy,
           spi_enable, spi_cpol, spi_cpha, spi_clk_sel, spi_master_data_in
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Round-robin sequencer sharing one SPI master among NREQ requesters.
// It latches the owner's mode and TX byte at grant and times enable by clk_sel.
// It captures the received byte and returns it with a one-cycle done pulse.
`timescale 1ns/1ps
module spi_xfer_sequencer #(
  parameter int NREQ      = 4,
  parameter int SETUP_CYC = 2,
  parameter int XFER_CYC0 = 22,
  parameter int XFER_CYC1 = 44,
  parameter int XFER_CYC2 = 175,
  parameter int XFER_CYC3 = 350,
  parameter int GAP_CYC   = 2,
  parameter int CNT_W     = 10
) (
  input logic clk,
  input logic reset,
  spi_xfer_sequencer_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, CAPTURE, GAP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [3:0]        cfg_q, cfg_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        rx_q, rx_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;

  logic              pick_found;
  logic [PTR_W-1:0]  pick_idx;
  logic [3:0]        pick_cfg;
  logic [7:0]        pick_tx;

  // Counter reload for the enable-high phase, chosen by the latched clk_sel.
  function automatic logic [CNT_W-1:0] xferReload(input logic [1:0] sel);
    case (sel)
      2'd0:    xferReload = CNT_W'(XFER_CYC0 - 1);
      2'd1:    xferReload = CNT_W'(XFER_CYC1 - 1);
      2'd2:    xferReload = CNT_W'(XFER_CYC2 - 1);
      default: xferReload = CNT_W'(XFER_CYC3 - 1);
    endcase
  endfunction

  // Round-robin pick: the first set request at or above ptr, else the first set request from 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_cfg   = '0;
    pick_tx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && bus.req[k] && (k >= int'(ptr_q))) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && bus.req[k]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == PTR_W'(k)) begin
        pick_cfg = bus.req_cfg[4*k +: 4];
        pick_tx  = bus.req_tx[8*k +: 8];
      end
    end
  end

  // State register and datapath registers. Reset aborts any transfer immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      cfg_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cfg_q   <= cfg_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. The counter is reloaded with (phase length - 1) on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cfg_d   = cfg_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    grant_d = grant_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          owner_d = pick_idx;
          cfg_d   = pick_cfg;
          tx_d    = pick_tx;
          grant_d = NREQ'(1) << pick_idx;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = XFER;
          cnt_d   = xferReload(cfg_q[1:0]);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      XFER: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CAPTURE: begin
        state_d = GAP;
        cnt_d   = CNT_W'(GAP_CYC - 1);
        rx_d    = bus.spi_master_data_out;
        done_d  = grant_q;
        grant_d = '0;
        ptr_d   = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state, so enable and busy are glitch-free.
  always_comb begin
    bus.spi_enable         = (state_q == XFER);
    bus.busy               = (state_q != IDLE);
    bus.grant              = grant_q;
    bus.done               = done_q;
    bus.rx_data            = rx_q;
    bus.spi_cpha           = cfg_q[3];
    bus.spi_cpol           = cfg_q[2];
    bus.spi_clk_sel        = cfg_q[1:0];
    bus.spi_master_data_in = tx_q;
  end

endmodule
